// File: rtl/collision_detector_if.sv
// Pixel-sequencer / CPU-side bundle for the VIC-II collision detector.
// main_border is present only when COLL_BORDER_MASK_EN is defined.
interface collision_detector_if #(
  parameter int NUM_SPR = 8
);
`ifdef COLL_BORDER_MASK_EN
  logic                   main_border;
`endif
  logic                   dot_rising_0;
  logic                   is_background_pixel;
  logic [2*NUM_SPR-1:0]   sprite_pix;
  logic [NUM_SPR-1:0]     sprite_mmc;
  logic                   rd_ssc;
  logic                   rd_sbc;
  logic [NUM_SPR-1:0]     ssc;
  logic [NUM_SPR-1:0]     sbc;
  logic                   immc_pulse;
  logic                   imbc_pulse;

  modport master (
`ifdef COLL_BORDER_MASK_EN
    output main_border,
`endif
    output dot_rising_0,
    output is_background_pixel,
    output sprite_pix,
    output sprite_mmc,
    output rd_ssc,
    output rd_sbc,
    input  ssc,
    input  sbc,
    input  immc_pulse,
    input  imbc_pulse
  );

  modport slave (
`ifdef COLL_BORDER_MASK_EN
    input  main_border,
`endif
    input  dot_rising_0,
    input  is_background_pixel,
    input  sprite_pix,
    input  sprite_mmc,
    input  rd_ssc,
    input  rd_sbc,
    output ssc,
    output sbc,
    output immc_pulse,
    output imbc_pulse
  );
endinterface

// File: rtl/collision_detector.sv
// Sprite-sprite ($D01E) and sprite-background ($D01F) collision registers with clear-on-read
// and first-collision pulses. Optional border masking is enabled by COLL_BORDER_MASK_EN.
module collision_detector #(
  parameter int NUM_SPR = 8
) (
  input logic                 clk_dot4x,
  input logic                 rst,
  collision_detector_if.slave bus
);

  logic [NUM_SPR-1:0] opq;
  logic [NUM_SPR-1:0] opq_q;
  logic               fg_q;
  logic               any_hit;
  logic               multi_hit;
  logic               coll_mask;
  logic [NUM_SPR-1:0] new_ss;
  logic [NUM_SPR-1:0] new_sb;
  logic [NUM_SPR-1:0] nss;
  logic [NUM_SPR-1:0] nsb;
  logic [NUM_SPR-1:0] ssc_eff;
  logic [NUM_SPR-1:0] sbc_eff;
  logic [NUM_SPR-1:0] ssc_q;
  logic [NUM_SPR-1:0] sbc_q;
  logic               immc_q;
  logic               imbc_q;

  // Multicolour sprites are opaque for any nonzero code; hires sprites only when the
  // upper bit is set, so hires code 01 is transparent.
  always_comb begin
    opq = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      opq[i] = bus.sprite_mmc[i] ? (bus.sprite_pix[2*i+1] | bus.sprite_pix[2*i])
                                 : bus.sprite_pix[2*i+1];
    end
  end

  // "Two or more set" chain: cheaper than a popcount adder and all stage 2 needs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    any_hit   = 1'b0;
    multi_hit = 1'b0;
    for (int i = 0; i < NUM_SPR; i++) begin
      multi_hit = multi_hit | (any_hit & opq_q[i]);
      any_hit   = any_hit | opq_q[i];
    end
  end

`ifdef COLL_BORDER_MASK_EN
  logic border_q;

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      border_q <= 1'b0;
    end else if (bus.dot_rising_0) begin
      border_q <= bus.main_border;
    end
  end

  assign coll_mask = border_q;
`else
  assign coll_mask = 1'b0;
`endif

  assign new_ss = (multi_hit && !coll_mask) ? opq_q : '0;
  assign new_sb = (fg_q && !coll_mask)      ? opq_q : '0;

  // Collision inputs exist only on the dot enable edge; a read clears before OR-ing
  // so a collision landing on the read edge is kept.
  assign nss     = bus.dot_rising_0 ? new_ss : '0;
  assign nsb     = bus.dot_rising_0 ? new_sb : '0;
  assign ssc_eff = bus.rd_ssc ? '0 : ssc_q;
  assign sbc_eff = bus.rd_sbc ? '0 : sbc_q;

  always_ff @(posedge clk_dot4x) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      opq_q  <= '0;
      fg_q   <= 1'b0;
      ssc_q  <= '0;
      sbc_q  <= '0;
      immc_q <= 1'b0;
      imbc_q <= 1'b0;
    end else begin
      if (bus.dot_rising_0) begin
        opq_q <= opq;
        fg_q  <= !bus.is_background_pixel;
      end
      ssc_q  <= ssc_eff | nss;
      sbc_q  <= sbc_eff | nsb;
      immc_q <= (ssc_eff == '0) && (nss != '0);
      imbc_q <= (sbc_eff == '0) && (nsb != '0);
    end
  end

  assign bus.ssc        = ssc_q;
  assign bus.sbc        = sbc_q;
  assign bus.immc_pulse = immc_q;
  assign bus.imbc_pulse = imbc_q;

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector: one dot = 4 clk_dot4x cycles, enable on the first.
module tb_collision_detector;

  logic clk_dot4x;
  logic rst;

  collision_detector_if #(.NUM_SPR(8)) bus ();

  collision_detector #(.NUM_SPR(8)) dut (
    .clk_dot4x (clk_dot4x),
    .rst       (rst),
    .bus       (bus)
  );

  initial clk_dot4x = 1'b0;
  always #5 clk_dot4x = ~clk_dot4x;

  int checks;
  int errors;

  logic [7:0] o_ssc;
  logic [7:0] o_sbc;
  logic       o_immc;
  logic       o_imbc;
  logic       o_immc2;
  logic       o_imbc2;

  // One dot: inputs valid on the enable edge, outputs captured 1 ns after it,
  // pulses captured again after the following edge.
  task automatic dot(input logic [15:0] pix, input logic [7:0] mmc, input logic bg,
                     input logic rs, input logic rb);
    @(negedge clk_dot4x);
    bus.sprite_pix          = pix;
    bus.sprite_mmc          = mmc;
    bus.is_background_pixel = bg;
    bus.rd_ssc              = rs;
    bus.rd_sbc              = rb;
    bus.dot_rising_0        = 1'b1;
    @(posedge clk_dot4x);
    #1;
    o_ssc  = bus.ssc;
    o_sbc  = bus.sbc;
    o_immc = bus.immc_pulse;
    o_imbc = bus.imbc_pulse;
    @(negedge clk_dot4x);
    bus.dot_rising_0 = 1'b0;
    bus.rd_ssc       = 1'b0;
    bus.rd_sbc       = 1'b0;
    @(posedge clk_dot4x);
    #1;
    o_immc2 = bus.immc_pulse;
    o_imbc2 = bus.imbc_pulse;
    repeat (2) @(posedge clk_dot4x);
  endtask

  // CPU read landing between dot enables.
  task automatic read_only(input logic rs, input logic rb);
    @(negedge clk_dot4x);
    bus.rd_ssc = rs;
    bus.rd_sbc = rb;
    @(posedge clk_dot4x);
    #1;
    o_ssc  = bus.ssc;
    o_sbc  = bus.sbc;
    o_immc = bus.immc_pulse;
    o_imbc = bus.imbc_pulse;
    @(negedge clk_dot4x);
    bus.rd_ssc = 1'b0;
    bus.rd_sbc = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk_dot4x);
    #1;
    checks++; if (bus.ssc !== 8'h00) begin errors++; $display("FAIL por_ssc got %h exp 00", bus.ssc); end
    checks++; if (bus.immc_pulse !== 1'b0 || bus.imbc_pulse !== 1'b0) begin
      errors++; $display("FAIL por_pulses got %b%b exp 00", bus.immc_pulse, bus.imbc_pulse); end
    @(negedge clk_dot4x);
    rst = 1'b0;
    // Sprites 0,1 over foreground twice: registers populated and stage 1 still loaded.
    dot(16'h000A, 8'h00, 1'b0, 1'b0, 1'b0);
    dot(16'h000A, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (o_ssc !== 8'h03 || o_sbc !== 8'h03) begin
      errors++; $display("FAIL pre_rst got ssc=%h sbc=%h exp 03/03", o_ssc, o_sbc); end
    @(negedge clk_dot4x);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_dot4x);
      #1;
      checks++; if (bus.ssc !== 8'h00 || bus.sbc !== 8'h00 || bus.immc_pulse !== 1'b0 || bus.imbc_pulse !== 1'b0) begin
        errors++; $display("FAIL rst_hold got ssc=%h sbc=%h pulses=%b%b exp 00/00/00",
                           bus.ssc, bus.sbc, bus.immc_pulse, bus.imbc_pulse); end
    end
    @(negedge clk_dot4x);
    rst = 1'b0;
    dot(16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (o_ssc !== 8'h00 || o_sbc !== 8'h00 || o_immc !== 1'b0 || o_imbc !== 1'b0) begin
      errors++; $display("FAIL post_rst got ssc=%h sbc=%h pulses=%b%b exp 00/00/00",
                         o_ssc, o_sbc, o_immc, o_imbc); end
  endtask

  task automatic test_sprite_sprite;
    dot(16'h0082, 8'h00, 1'b1, 1'b0, 1'b0);
    dot(16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (o_ssc !== 8'h09) begin errors++; $display("FAIL ss_03 got %h exp 09", o_ssc); end
    checks++; if (o_sbc !== 8'h00) begin errors++; $display("FAIL ss_03_sbc got %h exp 00", o_sbc); end
    checks++; if (o_immc !== 1'b1 || o_imbc !== 1'b0) begin
      errors++; $display("FAIL ss_03_pulse got %b%b exp 10", o_immc, o_imbc); end
    checks++; if (o_immc2 !== 1'b0) begin errors++; $display("FAIL ss_03_width got %b exp 0", o_immc2); end
  endtask

  task automatic test_opacity;
    dot(16'h0400, 8'h00, 1'b0, 1'b0, 1'b0);
    dot(16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (o_sbc !== 8'h00 || o_imbc !== 1'b0) begin
      errors++; $display("FAIL hires01 got sbc=%h imbc=%b exp 00/0", o_sbc, o_imbc); end
    dot(16'h0400, 8'h20, 1'b0, 1'b0, 1'b0);
    dot(16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (o_sbc !== 8'h20) begin errors++; $display("FAIL mc01_sbc got %h exp 20", o_sbc); end
    checks++; if (o_imbc !== 1'b1 || o_immc !== 1'b0 || o_imbc2 !== 1'b0) begin
      errors++; $display("FAIL mc01_pulse got imbc=%b immc=%b next=%b exp 1/0/0", o_imbc, o_immc, o_imbc2); end
    checks++; if (o_ssc !== 8'h09) begin errors++; $display("FAIL mc01_ssc got %h exp 09", o_ssc); end
  endtask

  task automatic test_accumulate;
    dot(16'h0028, 8'h00, 1'b1, 1'b0, 1'b0);
    dot(16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (o_ssc !== 8'h0F || o_immc !== 1'b0) begin
      errors++; $display("FAIL accum got ssc=%h immc=%b exp 0F/0", o_ssc, o_immc); end
    read_only(1'b1, 1'b0);
    checks++; if (o_ssc !== 8'h00 || o_immc !== 1'b0 || o_sbc !== 8'h20) begin
      errors++; $display("FAIL rd_idle got ssc=%h immc=%b sbc=%h exp 00/0/20", o_ssc, o_immc, o_sbc); end
    dot(16'h0028, 8'h00, 1'b1, 1'b0, 1'b0);
    dot(16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (o_ssc !== 8'h06 || o_immc !== 1'b1) begin
      errors++; $display("FAIL rearm got ssc=%h immc=%b exp 06/1", o_ssc, o_immc); end
  endtask

  task automatic test_read_collide;
    read_only(1'b0, 1'b1);
    checks++; if (o_sbc !== 8'h00 || o_ssc !== 8'h06) begin
      errors++; $display("FAIL rd_sbc got sbc=%h ssc=%h exp 00/06", o_sbc, o_ssc); end
    dot(16'h0002, 8'h00, 1'b0, 1'b0, 1'b0);
    dot(16'h0020, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (o_sbc !== 8'h01 || o_imbc !== 1'b1) begin
      errors++; $display("FAIL sb_0 got sbc=%h imbc=%b exp 01/1", o_sbc, o_imbc); end
    dot(16'h0000, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++; if (o_sbc !== 8'h04 || o_imbc !== 1'b1) begin
      errors++; $display("FAIL rd_and_set got sbc=%h imbc=%b exp 04/1", o_sbc, o_imbc); end
    checks++; if (o_ssc !== 8'h06 || o_immc !== 1'b0) begin
      errors++; $display("FAIL rd_sbc_only got ssc=%h immc=%b exp 06/0", o_ssc, o_immc); end
  endtask

  task automatic test_back_to_back;
    dot(16'hAAAA, 8'h00, 1'b0, 1'b0, 1'b0);
    dot(16'h0000, 8'h00, 1'b1, 1'b1, 1'b1);
    checks++; if (o_ssc !== 8'hFF || o_sbc !== 8'hFF) begin
      errors++; $display("FAIL all8 got ssc=%h sbc=%h exp FF/FF", o_ssc, o_sbc); end
    checks++; if (o_immc !== 1'b1 || o_imbc !== 1'b1) begin
      errors++; $display("FAIL all8_pulse got %b%b exp 11", o_immc, o_imbc); end
    dot(16'h0000, 8'h00, 1'b1, 1'b1, 1'b1);
    checks++; if (o_ssc !== 8'h00 || o_sbc !== 8'h00 || o_immc !== 1'b0 || o_imbc !== 1'b0) begin
      errors++; $display("FAIL rd_held got ssc=%h sbc=%h pulses=%b%b exp 00/00/00",
                         o_ssc, o_sbc, o_immc, o_imbc); end
  endtask

  task automatic test_border;
`ifdef COLL_BORDER_MASK_EN
    bus.main_border = 1'b1;
`endif
    dot(16'hA000, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef COLL_BORDER_MASK_EN
    bus.main_border = 1'b0;
`endif
    dot(16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef COLL_BORDER_MASK_EN
    checks++; if (o_ssc !== 8'h00 || o_immc !== 1'b0) begin
      errors++; $display("FAIL border1 got ssc=%h immc=%b exp 00/0", o_ssc, o_immc); end
`else
    checks++; if (o_ssc !== 8'hC0 || o_immc !== 1'b1) begin
      errors++; $display("FAIL border1 got ssc=%h immc=%b exp C0/1", o_ssc, o_immc); end
`endif
    read_only(1'b1, 1'b0);
    dot(16'hA000, 8'h00, 1'b1, 1'b0, 1'b0);
    dot(16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (o_ssc !== 8'hC0 || o_immc !== 1'b1) begin
      errors++; $display("FAIL border0 got ssc=%h immc=%b exp C0/1", o_ssc, o_immc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst                     = 1'b1;
    bus.dot_rising_0        = 1'b0;
    bus.is_background_pixel = 1'b1;
    bus.sprite_pix          = '0;
    bus.sprite_mmc          = '0;
    bus.rd_ssc              = 1'b0;
    bus.rd_sbc              = 1'b0;
`ifdef COLL_BORDER_MASK_EN
    bus.main_border         = 1'b0;
`endif
    test_reset();
    test_sprite_sprite();
    test_opacity();
    test_accumulate();
    test_read_collide();
    test_back_to_back();
    test_border();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
